fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, program-memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 15, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level; leave IDLE and begin fetching.
REQ-006 SHALL have port stop  input  1  level; stop fetching and return to IDLE.
REQ-007 SHALL have port jump_en  input  1  one-cycle redirect request from execute stage.
REQ-008 SHALL have port jump_addr  input  ADDR_WIDTH  redirect target.
REQ-009 SHALL have port rom_addr  output  ADDR_WIDTH  address to program memory, combinationally equal to PC.
REQ-010 SHALL have port rom_data  input  DATA_WIDTH  program-memory word, asynchronous read of rom_addr.
REQ-011 SHALL have port instr  output  DATA_WIDTH  registered instruction to decoder.
REQ-012 SHALL have port instr_pc  output  ADDR_WIDTH  registered address of instr.
REQ-013 SHALL have port instr_valid  output  1  instr/instr_pc hold a valid word.
REQ-014 SHALL have port instr_ready  input  1  decoder accepts instr this cycle.
REQ-015 SHALL have port pc_wrap  output  1  registered one-cycle pulse when PC wraps max->0.
REQ-016 SHALL have port running  output  1  high when state is RUN.

Function
REQ-017 SHALL implement a two-state FSM: IDLE, RUN.
REQ-018 IDLE -> RUN at the edge where start=1 and stop=0; RUN -> IDLE at any edge where stop=1; stop wins over start.
REQ-019 SHALL define "slot free" as (instr_valid=0) or (instr_ready=1).
REQ-020 In RUN with jump_en=0 and slot free, at the edge: instr<=rom_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
REQ-021 In RUN with slot not free (valid=1, ready=0): PC, instr, instr_pc, instr_valid SHALL hold (stall, no word lost or duplicated).
REQ-022 A handshake completes on an edge with instr_valid=1 and instr_ready=1; if no new fetch occurs that edge, instr_valid<=0.
REQ-023 jump_en=1 in RUN: PC<=jump_addr, instr_valid<=0 (flush), no fetch that edge; jump has priority over fetch and over stall.
REQ-024 jump_en in IDLE: PC<=jump_addr, instr_valid unchanged.
REQ-025 PC increment SHALL be modulo 2^ADDR_WIDTH; 255->0 (default) sets pc_wrap=1 for exactly the following cycle.
REQ-026 In IDLE no fetch; a held valid word SHALL remain until accepted, then instr_valid<=0.
REQ-027 stop and fetch same edge: fetch is suppressed (stop has priority over fetch, not over jump).
REQ-028 Latency: start sampled at edge N -> first instr_valid=1 after edge N+1, carrying word at PC; sustained throughput one word per cycle with instr_ready=1.
REQ-029 rom_addr SHALL always equal PC with no added register stage.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, PC=0, instr=0, instr_pc=0, instr_valid=0, pc_wrap=0, running=0.
REQ-031 Reset asserted mid-RUN SHALL discard any held word; after release the block stays IDLE until start.
REQ-032 No output SHALL change on clk while rst_n=0.

Verification
REQ-033 Reset, start=1 one cycle, ROM[i]=i, instr_ready=1 -> instr sequence 0,1,2,... one per cycle, instr_pc=instr.
REQ-034 Run to PC=255, ready=1 -> word at 255 followed by word at 0, pc_wrap=1 for exactly one cycle.
REQ-035 ready=0 for 3 cycles while valid at PC=10 -> instr/instr_pc stable at 10, rom_addr stays 11, no skip after ready=1.
REQ-036 jump_en=1, jump_addr=0x40 while valid word pending and ready=0 -> valid drops next cycle, next valid word has instr_pc=0x40.
REQ-037 stop=1 at PC=5 with ready=0 -> running=0, word 4 held until ready=1 then valid=0, PC remains 5.
REQ-038 rst_n pulled low between edges during RUN -> all outputs zero immediately, start required to resume from PC=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a PC through an asynchronous program memory and
// holds one fetched word in an output register with a valid/ready handshake.
module fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  pc_wrap,
  output logic                  running
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  slot_free;
  logic                  handshake;
  logic                  fetch;
  logic                  flush;

  assign slot_free = !instr_valid || instr_ready;
  assign handshake = instr_valid && instr_ready;
  // A fetch needs RUN, no stop, no redirect and room in the output register.
  assign fetch     = (state == RUN) && !stop && !jump_en && slot_free;
  assign flush     = (state == RUN) && jump_en;

  assign rom_addr  = pc;
  assign running   = (state == RUN);

  // NOTE: default assignment first so every path drives state_next (no latch).
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else if ((state == IDLE) && start) begin
      state_next = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      pc_wrap <= 1'b0;
    end else begin
      if (jump_en) begin
        pc <= jump_addr;
      end else if (fetch) begin
        pc <= pc + ADDR_WIDTH'(1);
      end
      pc_wrap <= fetch && (pc == PC_MAX);
    end
  end

  // Output word register: a redirect in RUN flushes it, a completed handshake
  // without a replacement fetch empties it, otherwise it holds (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (fetch) begin
      instr       <= rom_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (flush || handshake) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

  localparam int AW = 8;
  localparam int DW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          pc_wrap;
  logic          running;

  logic          rom_scr;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_wrap    (pc_wrap),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Program memory: identity contents, or a scrambled pattern so data and address differ.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a, input logic scr);
    logic [DW-1:0] p;
    p = DW'(a) * DW'(131);
    return scr ? (p ^ 15'h2AAA) : DW'(a);
  endfunction

  assign rom_data = rom_fn(rom_addr, rom_scr);

  // ---------------- behavioural model ----------------
  logic          m_run  = 1'b0;
  logic [AW-1:0] m_pc   = '0;
  logic          m_wrap = 1'b0;
  logic          m_has  = 1'b0;
  logic [AW-1:0] m_wpc  = '0;
  logic [DW-1:0] m_word = '0;
  logic          m_take;

  // A new word is taken whenever the machine runs, is not stopping or redirecting,
  // and the single output slot is empty or being drained this cycle.
  assign m_take = m_run && !stop && !jump_en && (!m_has || instr_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_pc   <= '0;
      m_wrap <= 1'b0;
      m_has  <= 1'b0;
      m_wpc  <= '0;
      m_word <= '0;
    end else begin
      m_run  <= stop ? 1'b0 : (start ? 1'b1 : m_run);
      m_pc   <= jump_en ? jump_addr : (m_take ? AW'((int'(m_pc) + 1) % 256) : m_pc);
      m_wrap <= m_take && (int'(m_pc) == 255);
      if (m_run && jump_en) begin
        m_has <= 1'b0;
      end else if (m_take) begin
        m_has  <= 1'b1;
        m_wpc  <= m_pc;
        m_word <= rom_fn(m_pc, rom_scr);
      end else if (instr_ready) begin
        m_has <= 1'b0;
      end
    end
  end

  // ---------------- literal pins requested by the stimulus ----------------
  logic          pin_en = 1'b0;
  logic          p_run, p_valid, p_wrap, p_chk;
  logic [AW-1:0] p_ipc, p_raddr;
  logic [DW-1:0] p_ins;

  task automatic pin(input logic run, input logic valid, input logic wrap,
                     input logic [AW-1:0] raddr, input logic chk,
                     input logic [AW-1:0] ipc, input logic [DW-1:0] ins);
    pin_en  = 1'b1;
    p_run   = run;
    p_valid = valid;
    p_wrap  = wrap;
    p_raddr = raddr;
    p_chk   = chk;
    p_ipc   = ipc;
    p_ins   = ins;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  // ---------------- single compare process ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    check("model_running", 32'(running), 32'(m_run));
    check("model_valid", 32'(instr_valid), 32'(m_has));
    check("model_rom_addr", 32'(rom_addr), 32'(m_pc));
    check("model_pc_wrap", 32'(pc_wrap), 32'(m_wrap));
    if (m_has) begin
      check("model_instr_pc", 32'(instr_pc), 32'(m_wpc));
      check("model_instr", 32'(instr), 32'(m_word));
    end
    if (pin_en) begin
      check("pin_running", 32'(running), 32'(p_run));
      check("pin_valid", 32'(instr_valid), 32'(p_valid));
      check("pin_pc_wrap", 32'(pc_wrap), 32'(p_wrap));
      check("pin_rom_addr", 32'(rom_addr), 32'(p_raddr));
      if (p_chk) begin
        check("pin_instr_pc", 32'(instr_pc), 32'(p_ipc));
        check("pin_instr", 32'(instr), 32'(p_ins));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; jump_en = 1'b0; jump_addr = '0;
    instr_ready = 1'b0; rom_scr = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state, start ignored while in reset
    tick(); pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000); start = 1'b1;
    tick(); pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000);
    tick(); pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000);
    start = 1'b0; rst_n = 1'b1;
    tick(); pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000);

    // Start for one cycle, streaming with ready=1, identity ROM
    instr_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0; pin(1, 0, 0, 8'h00, 0, '0, '0);
    tick(); pin(1, 1, 0, 8'h01, 1, 8'h00, 15'h0000);
    for (int i = 1; i <= 10; i++) begin
      tick(); pin(1, 1, 0, AW'(i + 1), 1, AW'(i), DW'(i));
    end

    // Stall three cycles with word 10 pending
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); pin(1, 1, 0, 8'h0B, 1, 8'h0A, 15'h000A);
    end
    instr_ready = 1'b1;
    tick(); pin(1, 1, 0, 8'h0C, 1, 8'h0B, 15'h000B);

    // Redirect to 0x40 while a word is pending and ready=0
    rom_scr = 1'b1; instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 8'h40;
    tick(); jump_en = 1'b0; pin(1, 0, 0, 8'h40, 0, '0, '0);
    tick(); pin(1, 1, 0, 8'h41, 1, 8'h40, 15'h0A6A);
    tick(); pin(1, 1, 0, 8'h41, 1, 8'h40, 15'h0A6A);

    // Wrap 0xFF -> 0x00
    instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 8'hFD;
    tick(); jump_en = 1'b0; pin(1, 0, 0, 8'hFD, 0, '0, '0);
    tick(); pin(1, 1, 0, 8'hFE, 0, '0, '0);
    tick(); pin(1, 1, 0, 8'hFF, 0, '0, '0);
    tick(); pin(1, 1, 1, 8'h00, 1, 8'hFF, 15'h28D7);
    tick(); pin(1, 1, 0, 8'h01, 1, 8'h00, 15'h2AAA);

    // Stop at PC=5 with ready=0: word 4 held, then drained
    rom_scr = 1'b0; jump_en = 1'b1; jump_addr = 8'h03;
    tick(); jump_en = 1'b0; pin(1, 0, 0, 8'h03, 0, '0, '0);
    tick(); pin(1, 1, 0, 8'h04, 1, 8'h03, 15'h0003);
    tick(); pin(1, 1, 0, 8'h05, 1, 8'h04, 15'h0004);
    instr_ready = 1'b0; stop = 1'b1;
    tick(); stop = 1'b0; pin(0, 1, 0, 8'h05, 1, 8'h04, 15'h0004);
    tick(); pin(0, 1, 0, 8'h05, 1, 8'h04, 15'h0004);
    instr_ready = 1'b1;
    tick(); pin(0, 0, 0, 8'h05, 0, '0, '0);
    tick(); pin(0, 0, 0, 8'h05, 0, '0, '0);

    // Jump in IDLE, stop beats start, then restart from the jump target
    jump_en = 1'b1; jump_addr = 8'h20;
    tick(); jump_en = 1'b0; pin(0, 0, 0, 8'h20, 0, '0, '0);
    start = 1'b1; stop = 1'b1;
    tick(); pin(0, 0, 0, 8'h20, 0, '0, '0);
    stop = 1'b0;
    tick(); start = 1'b0; pin(1, 0, 0, 8'h20, 0, '0, '0);
    tick(); pin(1, 1, 0, 8'h21, 1, 8'h20, 15'h0020);
    tick(); pin(1, 1, 0, 8'h22, 1, 8'h21, 15'h0021);

    // Asynchronous reset between edges during RUN
    tick();
    rst_n = 1'b0; pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000);
    start = 1'b1;
    tick(); pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000);
    rst_n = 1'b1; start = 1'b0;
    tick(); pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000);
    tick(); pin(0, 0, 0, 8'h00, 1, 8'h00, 15'h0000);
    start = 1'b1;
    tick(); start = 1'b0; pin(1, 0, 0, 8'h00, 0, '0, '0);
    tick(); pin(1, 1, 0, 8'h01, 1, 8'h00, 15'h0000);
    tick(); pin(1, 1, 0, 8'h02, 1, 8'h01, 15'h0001);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
